// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: a req/ack handshake carrying address,
// byte enables and store data out, load data back.
interface mem_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;

  modport master (
    output data_req, data_wr, data_be, data_addr, data_wdata,
    input  data_rdata, data_ack
  );

  modport slave (
    input  data_req, data_wr, data_be, data_addr, data_wdata,
    output data_rdata, data_ack
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Registers the execute outputs, runs one req/ack transaction per load/store
// with little-endian lane steering, and stalls upstream while it is pending.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned half/word accesses
// are flagged on addr_err and suppressed instead of issued).
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] inst_in,
  input  logic [4:0]  write_reg_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_we,
  output logic [31:0] inst_out,
  output logic        addr_err
);

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] inst;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
  } stage_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  stage_t      st_q, st_d;
  state_t      state_q, state_d;
  logic [31:0] ld_q;
  logic        ld_en, memop, mis, req;
  logic [5:0]  op;
  logic        is_byte, is_half, unsgn;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata, sh, ext;

  assign st_d = '{alu: alu_result_in, addr: mem_addr_in, sd: store_data_in,
                  inst: inst_in, wreg: write_reg_in, rw: reg_write_in,
                  m2r: mem_to_reg_in, mr: mem_read_in, mw: mem_write_in};

  // The stage only advances when neither the hazard unit nor this stage holds it.
  assign ld_en = !stall && !mem_stall;

  // Stage register; reset leaves a NOP bubble.
  always_ff @(posedge clk) begin
    if (rst)        st_q <= '0;
    else if (ld_en) st_q <= st_d;
  end

  // Width/sign decode: opcode[1:0] gives the size, opcode[2] the unsigned flavour.
  assign op      = st_q.inst[31:26];
  assign is_byte = (op[1:0] == 2'b00);
  assign is_half = (op[1:0] == 2'b01);
  assign unsgn   = op[2];
  assign memop   = st_q.mr | st_q.mw;

  // Low address bits below the access width are dropped, so a half uses a[1]
  // and a word always starts at lane 0.
  assign lane = is_byte ? st_q.addr[1:0] :
                is_half ? {st_q.addr[1], 1'b0} : 2'b00;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = memop && ((is_half && st_q.addr[0]) ||
                         (!is_byte && !is_half && (st_q.addr[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b1111;
    wdata = st_q.sd;
    if (is_byte) begin
      be    = 4'b0001 << lane;
      wdata = {4{st_q.sd[7:0]}};
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{st_q.sd[15:0]}};
    end
  end

  // Load extraction from the captured word with sign/zero extension.
  assign sh = ld_q >> {lane, 3'b000};
  always_comb begin
    ext = ld_q;
    if (is_byte)      ext = unsgn ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
    else if (is_half) ext = unsgn ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one transaction per instruction, DONE waits for the stage to advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memop && !mis) state_d = dmem.data_ack ? DONE : BUSY;
      BUSY:    if (dmem.data_ack) state_d = DONE;
      DONE:    if (ld_en)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request is raised in IDLE for a fresh mem op and held through BUSY.
  always_comb begin
    req       = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        req       = memop && !mis;
        mem_stall = memop && !mis;
      end
      BUSY: begin
        req       = 1'b1;
        mem_stall = 1'b1;
      end
      default: ;
    endcase
  end

  // Load data is captured on the ack edge and held for write-back.
  always_ff @(posedge clk) begin
    if (rst)                        ld_q <= '0;
    else if (req && dmem.data_ack)  ld_q <= dmem.data_rdata;
  end

  // The port stays quiet unless a request is active.
  assign dmem.data_req   = req;
  assign dmem.data_wr    = req & st_q.mw;
  assign dmem.data_be    = req ? be : 4'b0000;
  assign dmem.data_addr  = req ? {st_q.addr[31:2], 2'b00} : 32'h0;
  assign dmem.data_wdata = (req && st_q.mw) ? wdata : 32'h0;

  assign addr_err = mis;
  assign wb_data  = st_q.m2r ? ext : st_q.alu;
  assign wb_reg   = st_q.wreg;
  assign wb_we    = st_q.rw && !mis && !mem_stall;
  assign inst_out = st_q.inst;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] alu_result_in, mem_addr_in, store_data_in, inst_in;
  logic [4:0]  write_reg_in;
  logic        reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in;
  logic        mem_stall, wb_we, addr_err;
  logic [31:0] wb_data, inst_out;
  logic [4:0]  wb_reg;

  mem_stage_if dif();

  mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .alu_result_in(alu_result_in), .mem_addr_in(mem_addr_in),
    .store_data_in(store_data_in), .inst_in(inst_in),
    .write_reg_in(write_reg_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .dmem(dif.master),
    .mem_stall(mem_stall), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_we(wb_we), .inst_out(inst_out), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int reqcnt = 0, stallcnt = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wdata, last_addr;
  logic        last_wr;

  // expected state of the stage for the current cycle
  logic        m_chk = 1'b0, m_chk_wbd = 1'b0;
  logic        m_req, m_wr, m_stall, m_wb_we, m_addr_err;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_wb_data, m_inst;
  logic [4:0]  m_wb_reg;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference rules ----
  function automatic int sz_of(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100100, 6'b101000: return 1;
      6'b100001, 6'b100101, 6'b101001: return 2;
      default:                         return 4;
    endcase
  endfunction

  // first byte lane touched: address rounded down to the access size
  function automatic int lane_of(input logic [5:0] op, input logic [31:0] a);
    int s = sz_of(op);
    return (int'(a[1:0]) / s) * s;
  endfunction

  function automatic bit misal_of(input logic [5:0] op, input logic [31:0] a, input bit memop);
`ifdef MEM_ALIGN_CHECK_EN
    return memop && ((int'(a[1:0]) % sz_of(op)) != 0);
`else
    return 1'b0 && memop && a[0] && (op != 6'h0);
`endif
  endfunction

  function automatic logic [3:0] be_of(input logic [5:0] op, input logic [31:0] a);
    int s = sz_of(op);
    return 4'(((1 << s) - 1) << lane_of(op, a));
  endfunction

  function automatic logic [31:0] wdata_of(input logic [5:0] op, input logic [31:0] d);
    logic [31:0] w;
    int s = sz_of(op);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ext_of(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v, mask;
    int s = sz_of(op);
    v    = rd >> (8 * lane_of(op, a));
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * s)) - 32'h1);
    v    = v & mask;
    if (s < 4 && !op[2] && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- compare process ----
  always @(negedge clk) begin
    if (dif.data_req) begin
      reqcnt++;
      last_be = dif.data_be; last_wdata = dif.data_wdata;
      last_addr = dif.data_addr; last_wr = dif.data_wr;
    end
    if (mem_stall) stallcnt++;
    if (m_chk) begin
      cmp("data_req", 32'(dif.data_req), 32'(m_req));
      if (m_req) begin
        cmp("data_wr", 32'(dif.data_wr), 32'(m_wr));
        cmp("data_be", 32'(dif.data_be), 32'(m_be));
        cmp("data_addr", dif.data_addr, m_addr);
        if (m_wr) cmp("data_wdata", dif.data_wdata, m_wdata);
      end
      cmp("mem_stall", 32'(mem_stall), 32'(m_stall));
      cmp("wb_we", 32'(wb_we), 32'(m_wb_we));
      cmp("wb_reg", 32'(wb_reg), 32'(m_wb_reg));
      cmp("inst_out", inst_out, m_inst);
      cmp("addr_err", 32'(addr_err), 32'(m_addr_err));
      if (m_chk_wbd) cmp("wb_data", wb_data, m_wb_data);
    end
  end

  task automatic clr_inputs();
    alu_result_in = 0; mem_addr_in = 0; store_data_in = 0; inst_in = 0;
    write_reg_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
    mem_read_in = 0; mem_write_in = 0;
  endtask

  task automatic set_idle_model();
    m_req = 0; m_wr = 0; m_be = 0; m_addr = 0; m_wdata = 0; m_stall = 0;
    m_wb_we = 0; m_wb_reg = 0; m_inst = 0; m_addr_err = 0; m_wb_data = 0;
    m_chk_wbd = 1;
  endtask

  // Push one instruction through the stage. k = ack wait cycles, hold = stall
  // cycles applied once the instruction is complete, sbusy = stall while pending.
  task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] wr, input bit rw, input bit m2r,
                       input bit mr, input bit mw, input int k, input logic [31:0] rd,
                       input int hold, input bit sbusy);
    logic [31:0] inst;
    bit memop, mis;
    int r0;
    inst  = {op, 26'h12_3456};
    memop = mr | mw;
    mis   = misal_of(op, addr, memop);
    r0    = reqcnt;
    alu_result_in = alu; mem_addr_in = addr; store_data_in = sd; inst_in = inst;
    write_reg_in = wr; reg_write_in = rw; mem_to_reg_in = m2r;
    mem_read_in = mr; mem_write_in = mw; stall = 0;
    @(posedge clk); #1;
    clr_inputs();
    m_inst = inst; m_wb_reg = wr; m_addr_err = mis;
    if (memop && !mis) begin
      for (int i = 0; i <= k; i++) begin
        m_req = 1; m_wr = mw; m_be = be_of(op, addr); m_addr = {addr[31:2], 2'b00};
        m_wdata = wdata_of(op, sd); m_stall = 1; m_wb_we = 0; m_chk_wbd = 0;
        dif.data_ack   = (i == k);
        dif.data_rdata = (i == k) ? rd : 32'h5A5A_5A5A;
        stall = sbusy;
        @(posedge clk); #1;
      end
      dif.data_ack = 0; stall = 0;
    end
    m_req = 0; m_stall = 0; m_wb_we = rw && !mis;
    m_wb_data = m2r ? ext_of(op, addr, rd) : alu;
    m_chk_wbd = !(m2r && (mis || !memop));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1; stall = 1;
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    stall = 0;
    cmp("req_cycles", 32'(reqcnt - r0), (memop && !mis) ? 32'(k + 1) : 32'd0);
  endtask

  int s0;

  initial begin
    rst = 1; stall = 0; clr_inputs();
    dif.data_ack = 0; dif.data_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_req", 32'(dif.data_req), 32'd0);
    cmp("rst_stall", 32'(mem_stall), 32'd0);
    cmp("rst_wb_data", wb_data, 32'd0);
    cmp("rst_wb_we", 32'(wb_we), 32'd0);
    cmp("rst_inst", inst_out, 32'd0);
    rst = 0;
    set_idle_model(); m_chk = 1;
    @(posedge clk); #1;

    // ADDU pass-through
    issue(6'b000000, 32'h1234, 32'h0, 32'h0, 5'd2, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    cmp("addu_lit", wb_data, 32'h0000_1234);
    cmp("addu_we_lit", 32'(wb_we), 32'd1);

    // LB / LBU at 0x1003, zero-wait ack
    s0 = stallcnt;
    issue(6'b100000, 32'h0, 32'h1003, 32'h0, 5'd8, 1, 1, 1, 0, 0, 32'h80FF_FFFF, 0, 0);
    cmp("lb_lit", wb_data, 32'hFFFF_FF80);
    cmp("lb_be_lit", 32'(last_be), 32'h8);
    cmp("lb_stall_cyc", 32'(stallcnt - s0), 32'd1);
    issue(6'b100100, 32'h0, 32'h1003, 32'h0, 5'd9, 1, 1, 1, 0, 0, 32'h80FF_FFFF, 0, 0);
    cmp("lbu_lit", wb_data, 32'h0000_0080);

    // SH at 0x2002 with 3 wait cycles
    s0 = stallcnt;
    issue(6'b101001, 32'h2002, 32'h2002, 32'hABCD_1234, 5'd0, 0, 0, 0, 1, 3, 32'h0, 0, 0);
    cmp("sh_wdata_lit", last_wdata, 32'h1234_1234);
    cmp("sh_be_lit", 32'(last_be), 32'hC);
    cmp("sh_wr_lit", 32'(last_wr), 32'd1);
    cmp("sh_stall_cyc", 32'(stallcnt - s0), 32'd4);

    // LW then hazard stall held two cycles in DONE
    issue(6'b100011, 32'h0, 32'h4000, 32'h0, 5'd3, 1, 1, 1, 0, 1, 32'hDEAD_BEEF, 2, 0);
    cmp("lw_hold_lit", wb_data, 32'hDEAD_BEEF);

    // halves, stall asserted while the transaction is pending, byte store
    issue(6'b100001, 32'h0, 32'h5002, 32'h0, 5'd4, 1, 1, 1, 0, 2, 32'h8001_7FFF, 0, 1);
    cmp("lh_lit", wb_data, 32'hFFFF_8001);
    issue(6'b100101, 32'h0, 32'h5000, 32'h0, 5'd5, 1, 1, 1, 0, 0, 32'h8001_7FFF, 0, 0);
    cmp("lhu_lit", wb_data, 32'h0000_7FFF);
    issue(6'b101000, 32'h0, 32'h6001, 32'h0000_0055, 5'd0, 0, 0, 0, 1, 1, 32'h0, 0, 0);
    cmp("sb_wdata_lit", last_wdata, 32'h5555_5555);
    cmp("sb_be_lit", 32'(last_be), 32'h2);

    // LW at 0x3001: flagged when alignment checking is built in, word access otherwise
    issue(6'b100011, 32'h0, 32'h3001, 32'h0, 5'd6, 1, 1, 1, 0, 0, 32'hCAFE_F00D, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
    cmp("misal_err_lit", 32'(addr_err), 32'd1);
    cmp("misal_we_lit", 32'(wb_we), 32'd0);
`else
    cmp("lw3001_lit", wb_data, 32'hCAFE_F00D);
    cmp("lw3001_addr_lit", last_addr, 32'h0000_3000);
`endif

    // reset in the middle of a pending LW
    alu_result_in = 0; mem_addr_in = 32'h7000; inst_in = {6'b100011, 26'h0};
    write_reg_in = 5'd7; reg_write_in = 1; mem_to_reg_in = 1; mem_read_in = 1;
    @(posedge clk); #1;
    clr_inputs();
    m_req = 1; m_wr = 0; m_be = 4'hF; m_addr = 32'h7000; m_stall = 1; m_wb_we = 0;
    m_wb_reg = 5'd7; m_inst = {6'b100011, 26'h0}; m_addr_err = 0; m_chk_wbd = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    set_idle_model();
    rst = 0;
    @(negedge clk); #1;
    cmp("rst_busy_req_lit", 32'(dif.data_req), 32'd0);
    cmp("rst_busy_inst_lit", inst_out, 32'd0);
    @(posedge clk); #1;

    issue(6'b000000, 32'h0000_BEEF, 32'h0, 32'h0, 5'd10, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    issue(6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0, 0, 0);

    m_chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
